vga_line_monitor: RTL and testbench



---
 rtl/vga_line_monitor.sv | 188 ++++++++++++++++++
 tb/tb_vga_line_monitor.sv | 530 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_monitor.sv
// Receive-side VGA horizontal timing monitor: measures each line, recovers x position, declares lock.
// Define VGA_MON_ERRCNT_EN to build the saturating error counter behind err_count.
module vga_line_monitor #(
    parameter int H_TOTAL    = 1345,
    parameter int H_ACTIVE   = 1024,
    parameter int H_SYNC     = 132,
    parameter int LOCK_LINES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        de,
    output logic        locked,
    output logic [11:0] line_len,
    output logic [11:0] sync_len,
    output logic [11:0] active_len,
    output logic        meas_valid,
    output logic        err,
    output logic        pixel_valid,
    output logic [10:0] x_pos,
    output logic [15:0] err_count
);

    // state | meaning
    // SEARCH  | waiting for a first hsync rise; partial line is discarded
    // MEASURE | capturing every line, counting consecutive matches
    // LOCKED  | timing matches the configured mode
    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [11:0] CNT_MAX  = 12'hFFF;
    localparam logic [10:0] X_MAX    = 11'h7FF;
    localparam logic [11:0] L_TOTAL  = 12'(H_TOTAL);
    localparam logic [11:0] L_ACTIVE = 12'(H_ACTIVE);
    localparam logic [11:0] L_SYNC   = 12'(H_SYNC);
    localparam logic [3:0]  L_LOCK   = 4'(LOCK_LINES);

    logic        r_hs_q, r_hs_qq, r_de_q, r_de_qq;
    logic [11:0] r_period, r_sync, r_active;
    logic [11:0] r_line_len, r_sync_len, r_active_len;
    logic [1:0]  r_state;
    logic [3:0]  r_match_cnt;
    logic        r_meas_valid, r_err, r_pixel_valid;
    logic [10:0] r_x_pos;

    logic        w_rise, w_timeout, w_capture, w_match;
    logic [11:0] w_cap_len;
    logic [3:0]  w_match_inc;

    assign w_rise      = r_hs_q & ~r_hs_qq;
    assign w_cap_len   = (r_period == CNT_MAX) ? CNT_MAX : r_period + 12'd1;
    assign w_match     = (w_cap_len == L_TOTAL) && (r_sync == L_SYNC) && (r_active == L_ACTIVE);
    assign w_capture   = w_rise && (r_state != ST_SEARCH);
    // A rise on the same cycle as the would-be timeout restarts the line instead.
    assign w_timeout   = !w_rise && (r_state != ST_SEARCH) && (r_period == CNT_MAX - 12'd1);
    assign w_match_inc = r_match_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_q  <= 1'b0;
            r_hs_qq <= 1'b0;
            r_de_q  <= 1'b0;
            r_de_qq <= 1'b0;
        end else begin
            r_hs_q  <= hsync;
            r_hs_qq <= r_hs_q;
            r_de_q  <= de;
            r_de_qq <= r_de_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= 12'd0;
            r_sync   <= 12'd0;
            r_active <= 12'd0;
        end else if (w_rise) begin
            r_period <= 12'd0;
            r_sync   <= 12'd1;
            r_active <= {11'd0, r_de_q};
        end else begin
            if (r_period != CNT_MAX) r_period <= r_period + 12'd1;
            if (r_hs_q && r_sync != CNT_MAX) r_sync <= r_sync + 12'd1;
            if (r_de_q && r_active != CNT_MAX) r_active <= r_active + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_len   <= 12'd0;
            r_sync_len   <= 12'd0;
            r_active_len <= 12'd0;
            r_meas_valid <= 1'b0;
        end else begin
            r_meas_valid <= w_capture;
            if (w_capture) begin
                r_line_len   <= w_cap_len;
                r_sync_len   <= r_sync;
                r_active_len <= r_active;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SEARCH;
            r_match_cnt <= 4'd0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    r_match_cnt <= 4'd0;
                    if (w_rise) r_state <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        if (w_match) begin
                            r_match_cnt <= w_match_inc;
                            if (w_match_inc >= L_LOCK) r_state <= ST_LOCKED;
                        end else begin
                            r_match_cnt <= 4'd0;
                        end
                    end else if (w_timeout) begin
                        r_state     <= ST_SEARCH;
                        r_match_cnt <= 4'd0;
                        r_err       <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_rise) begin
                        if (!w_match) begin
                            r_state     <= ST_MEASURE;
                            r_match_cnt <= 4'd0;
                            r_err       <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state     <= ST_SEARCH;
                        r_match_cnt <= 4'd0;
                        r_err       <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_SEARCH;
                    r_match_cnt <= 4'd0;
                end
            endcase
        end
    end

    // x position follows de only; it is deliberately independent of lock state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel_valid <= 1'b0;
            r_x_pos       <= 11'd0;
        end else begin
            r_pixel_valid <= r_de_q;
            if (r_de_q) begin
                if (!r_de_qq) r_x_pos <= 11'd0;
                else if (r_x_pos != X_MAX) r_x_pos <= r_x_pos + 11'd1;
            end
        end
    end

`ifdef VGA_MON_ERRCNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err_count <= 16'd0;
        else if (r_err && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
    end

    assign err_count = r_err_count;
`else
    assign err_count = 16'd0;
`endif

    assign locked      = (r_state == ST_LOCKED);
    assign line_len    = r_line_len;
    assign sync_len    = r_sync_len;
    assign active_len  = r_active_len;
    assign meas_valid  = r_meas_valid;
    assign err         = r_err;
    assign pixel_valid = r_pixel_valid;
    assign x_pos       = r_x_pos;

endmodule

// File: tb/tb_vga_line_monitor.sv
// Self-checking bench for vga_line_monitor: line-level timing model plus per-cycle pixel model.
module tb_vga_line_monitor;
    localparam int H_TOTAL    = 1345;
    localparam int H_ACTIVE   = 1024;
    localparam int H_SYNC     = 132;
    localparam int LOCK_LINES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync = 1'b0;
    logic        de = 1'b0;
    logic        locked, meas_valid, err, pixel_valid;
    logic [11:0] line_len, sync_len, active_len;
    logic [10:0] x_pos;
    logic [15:0] err_count;

    vga_line_monitor #(
        .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .H_SYNC(H_SYNC), .LOCK_LINES(LOCK_LINES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .de(de),
        .locked(locked), .line_len(line_len), .sync_len(sync_len), .active_len(active_len),
        .meas_valid(meas_valid), .err(err), .pixel_valid(pixel_valid), .x_pos(x_pos),
        .err_count(err_count)
    );

    always #12 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observed events, recorded on the falling edge.
    int   mv_cyc[$], mv_ll[$], mv_sl[$], mv_al[$];
    int   er_cyc[$];
    int   lk_cyc[$], lk_val[$];
    logic mon_prev_lk = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (meas_valid) begin
                mv_cyc.push_back(cyc);
                mv_ll.push_back(int'(line_len));
                mv_sl.push_back(int'(sync_len));
                mv_al.push_back(int'(active_len));
            end
            if (err) er_cyc.push_back(cyc);
            if (locked !== mon_prev_lk) begin
                lk_cyc.push_back(cyc);
                lk_val.push_back(int'(locked));
            end
        end
        mon_prev_lk <= locked;
    end

    // Expected events produced by the line-level model.
    int ex_mv_cyc[$], ex_mv_ll[$], ex_mv_sl[$], ex_mv_al[$];
    int ex_er_cyc[$];
    int ex_lk_cyc[$], ex_lk_val[$];
    int s_mv, s_er, s_lk;

    bit m_seen, m_lk;
    int m_run, m_plen, m_psw, m_paw;

    int q_len[$], q_sw[$], q_aw[$], q_ds[$];

    task automatic add_line(input int len, input int sw, input int aw, input int ds);
        q_len.push_back(len);
        q_sw.push_back(sw);
        q_aw.push_back(aw);
        q_ds.push_back(ds);
    endtask

    task automatic add_good(input int n);
        for (int i = 0; i < n; i++)
            add_line(H_TOTAL, H_SYNC, H_ACTIVE, $urandom_range(H_SYNC, H_TOTAL - H_ACTIVE));
    endtask

    task automatic do_reset();
        hsync = 1'b0;
        de    = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_seen = 1'b0;
        m_lk   = 1'b0;
        m_run  = 0;
        ex_mv_cyc.delete(); ex_mv_ll.delete(); ex_mv_sl.delete(); ex_mv_al.delete();
        ex_er_cyc.delete(); ex_lk_cyc.delete(); ex_lk_val.delete();
        s_mv = mv_cyc.size();
        s_er = er_cyc.size();
        s_lk = lk_cyc.size();
    endtask

    // Drives queued lines and predicts measurements, lock changes and errors per line.
    task automatic play_lines();
        while (q_len.size() > 0) begin
            int len, sw, aw, ds, r, ll;
            bit match;
            len = q_len.pop_front();
            sw  = q_sw.pop_front();
            aw  = q_aw.pop_front();
            ds  = q_ds.pop_front();
            for (int k = 0; k < len; k++) begin
                @(posedge clk);
                #1;
                hsync = (k < sw);
                de    = (k >= ds) && (k < ds + aw);
                if (k == 0) begin
                    r = cyc;
                    if (m_seen) begin
                        ll = (m_plen > 4095) ? 4095 : m_plen;
                        ex_mv_cyc.push_back(r + 2);
                        ex_mv_ll.push_back(ll);
                        ex_mv_sl.push_back(m_psw);
                        ex_mv_al.push_back(m_paw);
                        match = (ll == H_TOTAL) && (m_psw == H_SYNC) && (m_paw == H_ACTIVE);
                        if (m_lk) begin
                            if (!match) begin
                                ex_er_cyc.push_back(r + 2);
                                ex_lk_cyc.push_back(r + 2);
                                ex_lk_val.push_back(0);
                                m_lk  = 1'b0;
                                m_run = 0;
                            end
                        end else begin
                            m_run = match ? m_run + 1 : 0;
                            if (m_run >= LOCK_LINES) begin
                                m_lk = 1'b1;
                                ex_lk_cyc.push_back(r + 2);
                                ex_lk_val.push_back(1);
                            end
                        end
                    end
                    m_seen = 1'b1;
                    m_plen = len;
                    m_psw  = sw;
                    m_paw  = aw;
                    if (len > 4095) begin
                        ex_er_cyc.push_back(r + 2 + 4095);
                        if (m_lk) begin
                            ex_lk_cyc.push_back(r + 2 + 4095);
                            ex_lk_val.push_back(0);
                        end
                        m_lk   = 1'b0;
                        m_run  = 0;
                        m_seen = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        hsync = 1'b0;
        de    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (locked !== 1'b0 || meas_valid !== 1'b0 || err !== 1'b0 || pixel_valid !== 1'b0 ||
            line_len !== 12'd0 || sync_len !== 12'd0 || active_len !== 12'd0 ||
            x_pos !== 11'd0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got lk=%b mv=%b er=%b pv=%b ll=%0d sl=%0d al=%0d x=%0d ec=%0d want all zero",
                     locked, meas_valid, err, pixel_valid, line_len, sync_len, active_len, x_pos, err_count);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        add_good(6);
        play_lines();
        checks++;
        if (mv_cyc.size() - s_mv != ex_mv_cyc.size()) begin
            errors++;
            $display("FAIL nominal_meas_count got %0d want %0d", mv_cyc.size() - s_mv, ex_mv_cyc.size());
        end
        for (int i = 0; i < ex_mv_cyc.size() && s_mv + i < mv_cyc.size(); i++) begin
            checks++;
            if (mv_cyc[s_mv+i] != ex_mv_cyc[i] || mv_ll[s_mv+i] != ex_mv_ll[i] ||
                mv_sl[s_mv+i] != ex_mv_sl[i] || mv_al[s_mv+i] != ex_mv_al[i]) begin
                errors++;
                $display("FAIL nominal_meas[%0d] got cyc=%0d len=%0d sync=%0d act=%0d want cyc=%0d len=%0d sync=%0d act=%0d",
                         i, mv_cyc[s_mv+i], mv_ll[s_mv+i], mv_sl[s_mv+i], mv_al[s_mv+i],
                         ex_mv_cyc[i], ex_mv_ll[i], ex_mv_sl[i], ex_mv_al[i]);
            end
        end
        checks++;
        if (lk_cyc.size() - s_lk != ex_lk_cyc.size()) begin
            errors++;
            $display("FAIL nominal_lock_count got %0d want %0d", lk_cyc.size() - s_lk, ex_lk_cyc.size());
        end
        for (int i = 0; i < ex_lk_cyc.size() && s_lk + i < lk_cyc.size(); i++) begin
            checks++;
            if (lk_cyc[s_lk+i] != ex_lk_cyc[i] || lk_val[s_lk+i] != ex_lk_val[i]) begin
                errors++;
                $display("FAIL nominal_lock[%0d] got cyc=%0d val=%0d want cyc=%0d val=%0d",
                         i, lk_cyc[s_lk+i], lk_val[s_lk+i], ex_lk_cyc[i], ex_lk_val[i]);
            end
        end
        checks++;
        if (er_cyc.size() - s_er != 0) begin
            errors++;
            $display("FAIL nominal_err_count got %0d want 0", er_cyc.size() - s_er);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL nominal_locked got %b want 1", locked);
        end
    endtask

    task automatic test_lock_loss();
        int ec_exp;
        do_reset();
        add_good(5);
        add_line(H_TOTAL - 1, H_SYNC, H_ACTIVE, 200);
        add_good(5);
        play_lines();
        checks++;
        if (mv_cyc.size() - s_mv != ex_mv_cyc.size()) begin
            errors++;
            $display("FAIL lockloss_meas_count got %0d want %0d", mv_cyc.size() - s_mv, ex_mv_cyc.size());
        end
        for (int i = 0; i < ex_mv_cyc.size() && s_mv + i < mv_cyc.size(); i++) begin
            checks++;
            if (mv_cyc[s_mv+i] != ex_mv_cyc[i] || mv_ll[s_mv+i] != ex_mv_ll[i] ||
                mv_sl[s_mv+i] != ex_mv_sl[i] || mv_al[s_mv+i] != ex_mv_al[i]) begin
                errors++;
                $display("FAIL lockloss_meas[%0d] got cyc=%0d len=%0d want cyc=%0d len=%0d",
                         i, mv_cyc[s_mv+i], mv_ll[s_mv+i], ex_mv_cyc[i], ex_mv_ll[i]);
            end
        end
        checks++;
        if (er_cyc.size() - s_er != ex_er_cyc.size()) begin
            errors++;
            $display("FAIL lockloss_err_count got %0d want %0d", er_cyc.size() - s_er, ex_er_cyc.size());
        end
        for (int i = 0; i < ex_er_cyc.size() && s_er + i < er_cyc.size(); i++) begin
            checks++;
            if (er_cyc[s_er+i] != ex_er_cyc[i]) begin
                errors++;
                $display("FAIL lockloss_err[%0d] got cyc=%0d want cyc=%0d", i, er_cyc[s_er+i], ex_er_cyc[i]);
            end
        end
        checks++;
        if (lk_cyc.size() - s_lk != ex_lk_cyc.size()) begin
            errors++;
            $display("FAIL lockloss_lock_count got %0d want %0d", lk_cyc.size() - s_lk, ex_lk_cyc.size());
        end
        for (int i = 0; i < ex_lk_cyc.size() && s_lk + i < lk_cyc.size(); i++) begin
            checks++;
            if (lk_cyc[s_lk+i] != ex_lk_cyc[i] || lk_val[s_lk+i] != ex_lk_val[i]) begin
                errors++;
                $display("FAIL lockloss_lock[%0d] got cyc=%0d val=%0d want cyc=%0d val=%0d",
                         i, lk_cyc[s_lk+i], lk_val[s_lk+i], ex_lk_cyc[i], ex_lk_val[i]);
            end
        end
`ifdef VGA_MON_ERRCNT_EN
        ec_exp = ex_er_cyc.size();
`else
        ec_exp = 0;
`endif
        checks++;
        if (int'(err_count) != ec_exp) begin
            errors++;
            $display("FAIL lockloss_err_count_port got %0d want %0d", err_count, ec_exp);
        end
    endtask

    task automatic test_timeout();
        int ec_exp;
        do_reset();
        add_good(1);
        add_line(4095, H_SYNC, H_ACTIVE, 300);
        add_good(5);
        add_line(H_TOTAL + 5000, H_SYNC, H_ACTIVE, 200);
        add_good(2);
        play_lines();
        checks++;
        if (mv_cyc.size() - s_mv != ex_mv_cyc.size()) begin
            errors++;
            $display("FAIL timeout_meas_count got %0d want %0d", mv_cyc.size() - s_mv, ex_mv_cyc.size());
        end
        for (int i = 0; i < ex_mv_cyc.size() && s_mv + i < mv_cyc.size(); i++) begin
            checks++;
            if (mv_cyc[s_mv+i] != ex_mv_cyc[i] || mv_ll[s_mv+i] != ex_mv_ll[i] ||
                mv_sl[s_mv+i] != ex_mv_sl[i] || mv_al[s_mv+i] != ex_mv_al[i]) begin
                errors++;
                $display("FAIL timeout_meas[%0d] got cyc=%0d len=%0d want cyc=%0d len=%0d",
                         i, mv_cyc[s_mv+i], mv_ll[s_mv+i], ex_mv_cyc[i], ex_mv_ll[i]);
            end
        end
        checks++;
        if (er_cyc.size() - s_er != ex_er_cyc.size()) begin
            errors++;
            $display("FAIL timeout_err_count got %0d want %0d", er_cyc.size() - s_er, ex_er_cyc.size());
        end
        for (int i = 0; i < ex_er_cyc.size() && s_er + i < er_cyc.size(); i++) begin
            checks++;
            if (er_cyc[s_er+i] != ex_er_cyc[i]) begin
                errors++;
                $display("FAIL timeout_err[%0d] got cyc=%0d want cyc=%0d", i, er_cyc[s_er+i], ex_er_cyc[i]);
            end
        end
        checks++;
        if (lk_cyc.size() - s_lk != ex_lk_cyc.size()) begin
            errors++;
            $display("FAIL timeout_lock_count got %0d want %0d", lk_cyc.size() - s_lk, ex_lk_cyc.size());
        end
        for (int i = 0; i < ex_lk_cyc.size() && s_lk + i < lk_cyc.size(); i++) begin
            checks++;
            if (lk_cyc[s_lk+i] != ex_lk_cyc[i] || lk_val[s_lk+i] != ex_lk_val[i]) begin
                errors++;
                $display("FAIL timeout_lock[%0d] got cyc=%0d val=%0d want cyc=%0d val=%0d",
                         i, lk_cyc[s_lk+i], lk_val[s_lk+i], ex_lk_cyc[i], ex_lk_val[i]);
            end
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout_locked_after got %b want 0", locked);
        end
`ifdef VGA_MON_ERRCNT_EN
        ec_exp = ex_er_cyc.size();
`else
        ec_exp = 0;
`endif
        checks++;
        if (int'(err_count) != ec_exp) begin
            errors++;
            $display("FAIL timeout_err_count_port got %0d want %0d", err_count, ec_exp);
        end
    endtask

    task automatic test_wrong_sync();
        do_reset();
        for (int i = 0; i < 5; i++) add_line(H_TOTAL, H_SYNC - 1, H_ACTIVE, 250);
        play_lines();
        checks++;
        if (mv_cyc.size() - s_mv != 4) begin
            errors++;
            $display("FAIL wrongsync_meas_count got %0d want 4", mv_cyc.size() - s_mv);
        end
        for (int i = s_mv; i < mv_cyc.size(); i++) begin
            checks++;
            if (mv_ll[i] != H_TOTAL || mv_sl[i] != H_SYNC - 1 || mv_al[i] != H_ACTIVE) begin
                errors++;
                $display("FAIL wrongsync_meas[%0d] got len=%0d sync=%0d act=%0d want len=%0d sync=%0d act=%0d",
                         i - s_mv, mv_ll[i], mv_sl[i], mv_al[i], H_TOTAL, H_SYNC - 1, H_ACTIVE);
            end
        end
        checks++;
        if (lk_cyc.size() - s_lk != 0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL wrongsync_lock got transitions=%0d locked=%b want 0 and 0",
                     lk_cyc.size() - s_lk, locked);
        end
    endtask

    task automatic test_pixel();
        int pat[$];
        int exp_pv[$], exp_x[$];
        int x, prev, n;
        do_reset();
        n = $urandom_range(3, 10);
        for (int i = 0; i < n; i++) pat.push_back(0);
        for (int i = 0; i < 1024; i++) pat.push_back(1);
        n = $urandom_range(20, 60);
        for (int i = 0; i < n; i++) pat.push_back(0);
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) pat.push_back(1);
        pat.push_back(0);
        for (int i = 0; i < 2100; i++) pat.push_back(1);
        for (int i = 0; i < 4; i++) pat.push_back(0);
        x = 0;
        prev = 0;
        foreach (pat[t]) begin
            if (pat[t] != 0) x = (prev == 0) ? 0 : ((x < 2047) ? x + 1 : 2047);
            exp_pv.push_back(pat[t]);
            exp_x.push_back(x);
            prev = pat[t];
        end
        n = pat.size();
        for (int k = 0; k < n + 2; k++) begin
            @(posedge clk);
            #1;
            de = (k < n) ? (pat[k] != 0) : 1'b0;
            @(negedge clk);
            if (k >= 2) begin
                checks++;
                if (int'(pixel_valid) != exp_pv[k-2] || int'(x_pos) != exp_x[k-2]) begin
                    errors++;
                    $display("FAIL pixel[%0d] got pv=%b x=%0d want pv=%0d x=%0d",
                             k - 2, pixel_valid, x_pos, exp_pv[k-2], exp_x[k-2]);
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        add_good(5);
        play_lines();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL midreset_prelock got %b want 1", locked);
        end
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            hsync = (k < H_SYNC);
            de    = (k >= 200) && (k < 200 + H_ACTIVE);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if (locked !== 1'b0 || meas_valid !== 1'b0 || err !== 1'b0 || pixel_valid !== 1'b0 ||
            line_len !== 12'd0 || sync_len !== 12'd0 || active_len !== 12'd0 ||
            x_pos !== 11'd0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL midreset_async got lk=%b ll=%0d sl=%0d al=%0d pv=%b x=%0d ec=%0d want all zero",
                     locked, line_len, sync_len, active_len, pixel_valid, x_pos, err_count);
        end
        do_reset();
        add_good(5);
        play_lines();
        checks++;
        if (mv_cyc.size() - s_mv != ex_mv_cyc.size()) begin
            errors++;
            $display("FAIL midreset_meas_count got %0d want %0d", mv_cyc.size() - s_mv, ex_mv_cyc.size());
        end
        checks++;
        if (lk_cyc.size() - s_lk != 1 || ex_lk_cyc.size() != 1) begin
            errors++;
            $display("FAIL midreset_lock_count got %0d want 1", lk_cyc.size() - s_lk);
        end else if (lk_cyc[s_lk] != ex_lk_cyc[0] || lk_val[s_lk] != 1) begin
            errors++;
            $display("FAIL midreset_lock_cyc got cyc=%0d val=%0d want cyc=%0d val=1",
                     lk_cyc[s_lk], lk_val[s_lk], ex_lk_cyc[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        add_good(4);
        for (int i = 0; i < 6; i++) begin
            int len, sw, aw, sel, d;
            len = H_TOTAL;
            sw  = H_SYNC;
            aw  = H_ACTIVE;
            sel = $urandom_range(0, 9);
            d   = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) d = -d;
            if (sel == 7) len = len + d;
            else if (sel == 8) sw = sw + d;
            else if (sel == 9) aw = aw + d;
            add_line(len, sw, aw, $urandom_range(1, len - aw));
        end
        play_lines();
        checks++;
        if (mv_cyc.size() - s_mv != ex_mv_cyc.size()) begin
            errors++;
            $display("FAIL random_meas_count got %0d want %0d", mv_cyc.size() - s_mv, ex_mv_cyc.size());
        end
        for (int i = 0; i < ex_mv_cyc.size() && s_mv + i < mv_cyc.size(); i++) begin
            checks++;
            if (mv_cyc[s_mv+i] != ex_mv_cyc[i] || mv_ll[s_mv+i] != ex_mv_ll[i] ||
                mv_sl[s_mv+i] != ex_mv_sl[i] || mv_al[s_mv+i] != ex_mv_al[i]) begin
                errors++;
                $display("FAIL random_meas[%0d] got cyc=%0d len=%0d sync=%0d act=%0d want cyc=%0d len=%0d sync=%0d act=%0d",
                         i, mv_cyc[s_mv+i], mv_ll[s_mv+i], mv_sl[s_mv+i], mv_al[s_mv+i],
                         ex_mv_cyc[i], ex_mv_ll[i], ex_mv_sl[i], ex_mv_al[i]);
            end
        end
        checks++;
        if (er_cyc.size() - s_er != ex_er_cyc.size()) begin
            errors++;
            $display("FAIL random_err_count got %0d want %0d", er_cyc.size() - s_er, ex_er_cyc.size());
        end
        for (int i = 0; i < ex_er_cyc.size() && s_er + i < er_cyc.size(); i++) begin
            checks++;
            if (er_cyc[s_er+i] != ex_er_cyc[i]) begin
                errors++;
                $display("FAIL random_err[%0d] got cyc=%0d want cyc=%0d", i, er_cyc[s_er+i], ex_er_cyc[i]);
            end
        end
        checks++;
        if (lk_cyc.size() - s_lk != ex_lk_cyc.size()) begin
            errors++;
            $display("FAIL random_lock_count got %0d want %0d", lk_cyc.size() - s_lk, ex_lk_cyc.size());
        end
        for (int i = 0; i < ex_lk_cyc.size() && s_lk + i < lk_cyc.size(); i++) begin
            checks++;
            if (lk_cyc[s_lk+i] != ex_lk_cyc[i] || lk_val[s_lk+i] != ex_lk_val[i]) begin
                errors++;
                $display("FAIL random_lock[%0d] got cyc=%0d val=%0d want cyc=%0d val=%0d",
                         i, lk_cyc[s_lk+i], lk_val[s_lk+i], ex_lk_cyc[i], ex_lk_val[i]);
            end
        end
    endtask

    initial begin
        #(64'd6_000_000);
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_lock_loss();
        test_timeout();
        test_wrong_sync();
        test_pixel();
        test_reset_midline();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
